// File: rtl/rp_reconfig_ctrl.sv
// rtl/rp_reconfig_ctrl.sv - partial-reconfiguration sequencer for the RP AXIS datapath
// Gates ingress at packet boundaries, drains the RP, isolates it while loading, then resumes.
module rp_reconfig_ctrl #(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_TUSER_WIDTH = 256,
  parameter int CNT_WIDTH        = 8,
  parameter int DRAIN_TIMEOUT    = 4096,
  parameter int RESUME_CYCLES    = 16
) (
  input  logic                          axis_aclk,
  input  logic                          axis_resetn,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]    m_rp_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]  m_rp_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]   m_rp_axis_tuser,
  output logic                          m_rp_axis_tvalid,
  input  logic                          m_rp_axis_tready,
  output logic                          m_rp_axis_tlast,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_rp_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]  s_rp_axis_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]   s_rp_axis_tuser,
  input  logic                          s_rp_axis_tvalid,
  output logic                          s_rp_axis_tready,
  input  logic                          s_rp_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  input  logic                          reconfig_req,
  input  logic                          reconfig_done,
  input  logic [15:0]                   cfg_dest_port,
  input  logic                          cfg_wr,
  output logic [15:0]                   DEST_PORT_NUM,
  output logic                          decouple,
  output logic                          rp_resetn,
  output logic                          reconfig_ack,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int DT_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam int RC_W = $clog2(RESUME_CYCLES + 1);

  typedef enum logic [2:0] {S_RUN, S_STOP, S_DRAIN, S_DECOUPLE, S_RESUME} state_t;

  state_t                state, state_next;
  logic [CNT_WIDTH-1:0]  in_flight;
  logic                  in_pkt, in_pkt_next;
  logic [DT_W-1:0]       drain_timer;
  logic [RC_W-1:0]       resume_timer;
  logic [15:0]           dest_shadow;
  logic                  ingress_open, ing_acc, ing_last, eg_last;
  logic                  drain_tmo, underflow, isolate_next;

  assign m_rp_axis_tdata = s_axis_tdata;
  assign m_rp_axis_tkeep = s_axis_tkeep;
  assign m_rp_axis_tuser = s_axis_tuser;
  assign m_rp_axis_tlast = s_axis_tlast;
  assign m_axis_tdata    = s_rp_axis_tdata;
  assign m_axis_tkeep    = s_rp_axis_tkeep;
  assign m_axis_tuser    = s_rp_axis_tuser;
  assign m_axis_tlast    = s_rp_axis_tlast;

  // New packets may only start in RUN; STOP lets the current packet finish.
  assign ingress_open     = (state == S_RUN) || ((state == S_STOP) && in_pkt);
  assign m_rp_axis_tvalid = ingress_open && s_axis_tvalid;
  assign s_axis_tready    = ingress_open && m_rp_axis_tready;

  // While isolated the RP output is swallowed so garbage never reaches downstream.
  assign m_axis_tvalid    = !decouple && s_rp_axis_tvalid;
  assign s_rp_axis_tready = decouple || m_axis_tready;

  assign ing_acc     = m_rp_axis_tvalid && m_rp_axis_tready;
  assign ing_last    = ing_acc && s_axis_tlast;
  assign eg_last     = !decouple && s_rp_axis_tvalid && m_axis_tready && s_rp_axis_tlast;
  assign in_pkt_next = ing_acc ? !s_axis_tlast : in_pkt;
  assign underflow   = eg_last && !ing_last && (in_flight == '0);
  assign drain_tmo   = (state == S_DRAIN) && (in_flight != '0) &&
                       (drain_timer == DT_W'(DRAIN_TIMEOUT - 1));
  assign isolate_next = (state_next == S_DECOUPLE) || (state_next == S_RESUME);
  assign busy        = (state != S_RUN);

  always_comb begin
    state_next = state;
    case (state)
      S_RUN:      if (reconfig_req) state_next = S_STOP;
      S_STOP:     if (!in_pkt_next) state_next = S_DRAIN;
      S_DRAIN:    if ((in_flight == '0) || drain_tmo) state_next = S_DECOUPLE;
      S_DECOUPLE: if (reconfig_done) state_next = S_RESUME;
      S_RESUME:   if (resume_timer == RC_W'(RESUME_CYCLES - 1)) state_next = S_RUN;
      default:    state_next = S_RUN;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state         <= S_RUN;
      in_flight     <= '0;
      in_pkt        <= 1'b0;
      drain_timer   <= '0;
      resume_timer  <= '0;
      decouple      <= 1'b0;
      rp_resetn     <= 1'b0;
      reconfig_ack  <= 1'b0;
      timeout_err   <= 1'b0;
      dest_shadow   <= 16'h0FA0;
      DEST_PORT_NUM <= 16'h0FA0;
    end else begin
      state        <= state_next;
      in_pkt       <= in_pkt_next;
      drain_timer  <= (state == S_DRAIN) ? drain_timer + 1'b1 : '0;
      resume_timer <= (state == S_RESUME) ? resume_timer + 1'b1 : '0;
      decouple     <= isolate_next;
      rp_resetn    <= !isolate_next;
      reconfig_ack <= (state == S_RESUME) && (state_next == S_RUN);
      timeout_err  <= timeout_err || drain_tmo || underflow;

      if ((state_next == S_DECOUPLE) && (state != S_DECOUPLE)) begin
        in_flight <= '0;
      end else if (ing_last && !eg_last) begin
        if (in_flight != '1) in_flight <= in_flight + 1'b1;
      end else if (eg_last && !ing_last) begin
        if (in_flight != '0) in_flight <= in_flight - 1'b1;
      end

      if (cfg_wr) dest_shadow <= cfg_dest_port;
      // Covers both steady RUN and the RESUME->RUN edge; a same-cycle write bypasses the shadow.
      if ((state == S_RUN) || (state_next == S_RUN))
        DEST_PORT_NUM <= cfg_wr ? cfg_dest_port : dest_shadow;
    end
  end

endmodule

// File: tb/tb_rp_reconfig_ctrl.sv
// tb/tb_rp_reconfig_ctrl.sv - directed self-checking bench for rp_reconfig_ctrl
module tb_rp_reconfig_ctrl;
  localparam int DW = 32;
  localparam int UW = 8;
  localparam int DT = 64;
  localparam int RC = 16;

  logic            axis_aclk = 1'b0;
  logic            axis_resetn;
  logic [DW-1:0]   s_axis_tdata, m_rp_axis_tdata, s_rp_axis_tdata, m_axis_tdata;
  logic [DW/8-1:0] s_axis_tkeep, m_rp_axis_tkeep, s_rp_axis_tkeep, m_axis_tkeep;
  logic [UW-1:0]   s_axis_tuser, m_rp_axis_tuser, s_rp_axis_tuser, m_axis_tuser;
  logic            s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic            m_rp_axis_tvalid, m_rp_axis_tready, m_rp_axis_tlast;
  logic            s_rp_axis_tvalid, s_rp_axis_tready, s_rp_axis_tlast;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic            reconfig_req, reconfig_done, cfg_wr;
  logic [15:0]     cfg_dest_port, DEST_PORT_NUM;
  logic            decouple, rp_resetn, reconfig_ack, busy, timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 axis_aclk = ~axis_aclk;

  rp_reconfig_ctrl #(
    .AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW), .CNT_WIDTH(8),
    .DRAIN_TIMEOUT(DT), .RESUME_CYCLES(RC)
  ) dut (
    .axis_aclk(axis_aclk), .axis_resetn(axis_resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_rp_axis_tdata(m_rp_axis_tdata), .m_rp_axis_tkeep(m_rp_axis_tkeep),
    .m_rp_axis_tuser(m_rp_axis_tuser), .m_rp_axis_tvalid(m_rp_axis_tvalid),
    .m_rp_axis_tready(m_rp_axis_tready), .m_rp_axis_tlast(m_rp_axis_tlast),
    .s_rp_axis_tdata(s_rp_axis_tdata), .s_rp_axis_tkeep(s_rp_axis_tkeep),
    .s_rp_axis_tuser(s_rp_axis_tuser), .s_rp_axis_tvalid(s_rp_axis_tvalid),
    .s_rp_axis_tready(s_rp_axis_tready), .s_rp_axis_tlast(s_rp_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .reconfig_req(reconfig_req), .reconfig_done(reconfig_done),
    .cfg_dest_port(cfg_dest_port), .cfg_wr(cfg_wr), .DEST_PORT_NUM(DEST_PORT_NUM),
    .decouple(decouple), .rp_resetn(rp_resetn), .reconfig_ack(reconfig_ack),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge axis_aclk);
      #1;
    end
  endtask

  // Walks DECOUPLE -> RESUME -> RUN; leaves the bench in the ack cycle.
  task automatic finish_reconfig(input string tag, input logic [15:0] dest_before,
                                 input logic [15:0] dest_after);
    reconfig_done = 1'b1;
    tick();
    reconfig_done = 1'b0;
    tick(RC - 1);
    check({tag, "_resume_dec"}, decouple, 1'b1);
    check({tag, "_resume_ack"}, reconfig_ack, 1'b0);
    check({tag, "_resume_dest"}, DEST_PORT_NUM, dest_before);
    tick();
    check({tag, "_ack"}, reconfig_ack, 1'b1);
    check({tag, "_ack_dec"}, decouple, 1'b0);
    check({tag, "_ack_rst"}, rp_resetn, 1'b1);
    check({tag, "_ack_busy"}, busy, 1'b0);
    check({tag, "_ack_dest"}, DEST_PORT_NUM, dest_after);
  endtask

  initial begin
    axis_resetn = 1'b0;
    s_axis_tdata = 32'hA5A5_0001; s_axis_tkeep = 4'hF; s_axis_tuser = 8'h3C;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_rp_axis_tready = 1'b1;
    s_rp_axis_tdata = 32'h5A5A_0002; s_rp_axis_tkeep = 4'h3; s_rp_axis_tuser = 8'hC3;
    s_rp_axis_tvalid = 1'b0; s_rp_axis_tlast = 1'b0; m_axis_tready = 1'b1;
    reconfig_req = 1'b0; reconfig_done = 1'b0; cfg_wr = 1'b0; cfg_dest_port = 16'h0;

    // Reset and idle
    tick(2);
    check("rst_rp_resetn", rp_resetn, 1'b0);
    check("rst_dest", DEST_PORT_NUM, 16'h0FA0);
    axis_resetn = 1'b1;
    tick(4);
    check("idle_dec", decouple, 1'b0);
    check("idle_rst", rp_resetn, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("idle_err", timeout_err, 1'b0);
    check("idle_ack", reconfig_ack, 1'b0);
    s_axis_tvalid = 1'b1; s_rp_axis_tvalid = 1'b1; m_rp_axis_tready = 1'b0;
    #1;
    check("pass_in_valid", m_rp_axis_tvalid, 1'b1);
    check("pass_in_ready", s_axis_tready, 1'b0);
    check("pass_in_data", m_rp_axis_tdata, 32'hA5A5_0001);
    check("pass_eg_valid", m_axis_tvalid, 1'b1);
    check("pass_eg_data", {m_axis_tkeep, m_axis_tuser}, {4'h3, 8'hC3});
    s_axis_tvalid = 1'b0; s_rp_axis_tvalid = 1'b0; m_rp_axis_tready = 1'b1;
    reconfig_done = 1'b1;
    tick();
    reconfig_done = 1'b0;
    check("done_in_run_ignored", busy, 1'b0);

    // Reconfig with no traffic
    reconfig_req = 1'b1;
    tick();
    reconfig_req = 1'b0;
    check("t2_stop_busy", busy, 1'b1);
    check("t2_stop_dec", decouple, 1'b0);
    tick();
    check("t2_drain_dec", decouple, 1'b0);
    tick();
    check("t2_dec", decouple, 1'b1);
    check("t2_dec_rst", rp_resetn, 1'b0);
    s_rp_axis_tvalid = 1'b1; m_axis_tready = 1'b0;
    #1;
    check("t2_discard_ready", s_rp_axis_tready, 1'b1);
    check("t2_discard_valid", m_axis_tvalid, 1'b0);
    s_rp_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    tick(6);
    check("t2_wait_dec", decouple, 1'b1);
    finish_reconfig("t2", 16'h0FA0, 16'h0FA0);
    tick();
    check("t2_ack_pulse", reconfig_ack, 1'b0);

    // Request mid-packet: packet completes, next packet blocked until ack
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
    tick();
    reconfig_req = 1'b1;
    #1;
    check("t3_beat2_ready", s_axis_tready, 1'b1);
    tick();
    reconfig_req = 1'b0;
    check("t3_stop_busy", busy, 1'b1);
    s_axis_tlast = 1'b1;
    #1;
    check("t3_beat3_ready", s_axis_tready, 1'b1);
    tick();
    s_axis_tlast = 1'b0;
    #1;
    check("t3_next_blocked", s_axis_tready, 1'b0);
    check("t3_next_valid", m_rp_axis_tvalid, 1'b0);
    s_rp_axis_tvalid = 1'b1; s_rp_axis_tlast = 1'b1;
    tick();
    s_rp_axis_tvalid = 1'b0; s_rp_axis_tlast = 1'b0;
    check("t3_drain_cnt0", decouple, 1'b0);
    tick();
    check("t3_dec", decouple, 1'b1);
    finish_reconfig("t3", 16'h0FA0, 16'h0FA0);
    check("t3_ack_ready", s_axis_tready, 1'b1);
    check("t3_err", timeout_err, 1'b0);
    s_axis_tvalid = 1'b0;
    tick();

    // Downstream stall holds DRAIN until egress tlast
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1;
    tick();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    reconfig_req = 1'b1; m_axis_tready = 1'b0;
    s_rp_axis_tvalid = 1'b1; s_rp_axis_tlast = 1'b1;
    tick();
    reconfig_req = 1'b0;
    tick();
    check("t4_eg_valid", m_axis_tvalid, 1'b1);
    check("t4_eg_ready", s_rp_axis_tready, 1'b0);
    tick(50);
    check("t4_stall_busy", busy, 1'b1);
    check("t4_stall_dec", decouple, 1'b0);
    m_axis_tready = 1'b1;
    tick();
    s_rp_axis_tvalid = 1'b0; s_rp_axis_tlast = 1'b0;
    check("t4_cnt0_dec", decouple, 1'b0);
    tick();
    check("t4_dec", decouple, 1'b1);
    check("t4_err", timeout_err, 1'b0);
    finish_reconfig("t4", 16'h0FA0, 16'h0FA0);
    tick();

    // Drain timeout: RP never emits tlast
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1;
    tick();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    reconfig_req = 1'b1;
    tick();
    reconfig_req = 1'b0;
    tick();
    tick(DT - 1);
    check("t5_pre_dec", decouple, 1'b0);
    check("t5_pre_err", timeout_err, 1'b0);
    tick();
    check("t5_dec", decouple, 1'b1);
    check("t5_err", timeout_err, 1'b1);
    finish_reconfig("t5", 16'h0FA0, 16'h0FA0);
    tick(3);
    check("t5_err_sticky", timeout_err, 1'b1);

    // Reset mid-sequence, then config shadowing
    reconfig_req = 1'b1;
    tick(3);
    reconfig_req = 1'b0;
    check("t7_in_dec", decouple, 1'b1);
    axis_resetn = 1'b0;
    #1;
    check("t7_async_dec", decouple, 1'b0);
    check("t7_async_busy", busy, 1'b0);
    check("t7_async_err", timeout_err, 1'b0);
    tick();
    axis_resetn = 1'b1;
    tick();
    check("t7_rst_release", rp_resetn, 1'b1);

    cfg_wr = 1'b1; cfg_dest_port = 16'd1234;
    tick();
    cfg_wr = 1'b0;
    check("t6_run_wr", DEST_PORT_NUM, 16'd1234);
    cfg_wr = 1'b1; cfg_dest_port = 16'd4000;
    tick();
    cfg_wr = 1'b0;
    reconfig_req = 1'b1;
    tick(3);
    reconfig_req = 1'b0;
    check("t6_dec", decouple, 1'b1);
    cfg_wr = 1'b1; cfg_dest_port = 16'd7777;
    tick();
    cfg_dest_port = 16'd5000;
    tick();
    cfg_wr = 1'b0;
    check("t6_deferred", DEST_PORT_NUM, 16'd4000);
    finish_reconfig("t6", 16'd4000, 16'd5000);

    // Egress tlast with nothing in flight flags underflow
    s_rp_axis_tvalid = 1'b1; s_rp_axis_tlast = 1'b1;
    tick();
    s_rp_axis_tvalid = 1'b0; s_rp_axis_tlast = 1'b0;
    check("t8_underflow", timeout_err, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rp_reconfig_ctrl.md
Name: rp_reconfig_ctrl

Overview:
Sequences partial reconfiguration of the reconfigurable partition (RP) AXIS datapath. It sits between the upstream AXIS source and the RP ingress, and between the RP egress and downstream. On request it stops new packets at a packet boundary, drains packets in flight inside the RP, decouples and resets the RP while the bitstream loads, then resumes traffic. It also owns the DEST_PORT_NUM configuration register that feeds the RP.

Parameters:
AXIS_DATA_WIDTH, 512, tdata width; tkeep is AXIS_DATA_WIDTH/8.
AXIS_TUSER_WIDTH, 256, tuser width.
CNT_WIDTH, 8, width of the in-flight packet counter.
DRAIN_TIMEOUT, 4096, maximum DRAIN cycles before forcing decouple.
RESUME_CYCLES, 16, cycles rp_resetn is held low after reconfig_done.

Ports:
axis_aclk  in  1  single clock.
axis_resetn  in  1  asynchronous active-low reset.
s_axis_tdata/tkeep/tuser/tvalid/tready/tlast  in/in/in/in/out/in  per params  upstream ingress.
m_rp_axis_tdata/tkeep/tuser/tvalid/tready/tlast  out/out/out/out/in/out  per params  to RP slave.
s_rp_axis_tdata/tkeep/tuser/tvalid/tready/tlast  in/in/in/in/out/in  per params  from RP master.
m_axis_tdata/tkeep/tuser/tvalid/tready/tlast  out/out/out/out/in/out  per params  downstream egress.
reconfig_req  in  1  level request; sampled in RUN only.
reconfig_done  in  1  one-cycle pulse from PR loader; honoured in DECOUPLE only.
cfg_dest_port  in  16  new DEST_PORT_NUM value.
cfg_wr  in  1  write strobe for cfg_dest_port.
DEST_PORT_NUM  out  16  registered config to RP.
decouple  out  1  high while RP is isolated.
rp_resetn  out  1  active-low RP reset.
reconfig_ack  out  1  one-cycle pulse on return to RUN.
busy  out  1  high in any state except RUN.
timeout_err  out  1  sticky; set on drain timeout or counter underflow.

Behaviour:
- Reset values: state RUN, decouple 0, rp_resetn 0 during reset then 1, reconfig_ack 0, busy 0, timeout_err 0, DEST_PORT_NUM 16'h0FA0, in-flight count 0, in_pkt 0.
- Data, tkeep, tuser and tlast pass through combinationally in both directions; only valid and ready are gated; zero latency.
- ingress_open = (RUN) or (STOP and in_pkt). When open: m_rp_axis_tvalid = s_axis_tvalid and s_axis_tready = m_rp_axis_tready. When closed: both are 0.
- Egress: when decouple=0, m_axis_tvalid = s_rp_axis_tvalid and s_rp_axis_tready = m_axis_tready. When decouple=1: m_axis_tvalid = 0 and s_rp_axis_tready = 1, so RP garbage is discarded.
- in_pkt: set on an accepted ingress beat with tlast=0; cleared on an accepted ingress beat with tlast=1.
- In-flight count:
  - +1 on an accepted ingress tlast beat.
  - -1 on an accepted egress tlast beat while decouple=0.
  - Both in the same cycle: count unchanged.
  - Decrement at 0: hold at 0 and set timeout_err.
  - Increment at all-ones: saturate.
  - Cleared to 0 on entry to DECOUPLE.
- FSM:
  - RUN: if reconfig_req=1, go to STOP.
  - STOP: go to DRAIN when in_pkt=0 at the clock edge, including the edge that accepts the tlast beat.
  - DRAIN: the drain timer starts at 0 on entry and increments each cycle. If count=0, go to DECOUPLE. Else if timer = DRAIN_TIMEOUT-1, set timeout_err and go to DECOUPLE.
  - DECOUPLE: decouple=1 and rp_resetn=0. Wait for reconfig_done, then go to RESUME. reconfig_done in any other state is ignored.
  - RESUME: decouple=1 and rp_resetn=0 for RESUME_CYCLES cycles, then go to RUN with reconfig_ack=1 for one cycle. decouple and rp_resetn deassert in the first RUN cycle.
- decouple and rp_resetn are registered outputs derived from the next state.
- DEST_PORT_NUM config:
  - cfg_wr writes a shadow register at any time; the last write wins.
  - Shadow copies to DEST_PORT_NUM immediately while in RUN.
  - Outside RUN, the copy is deferred to the RESUME→RUN transition.
- reconfig_req held high through RUN re-entry starts a new cycle on the cycle after ack. Sequence timing is unchanged.
- Asynchronous reset mid-sequence returns to RUN immediately; the counter and flags clear. timeout_err clears only on reset.

Test Plan:
1. Reset, then idle 4 cycles → decouple=0, rp_resetn=1, busy=0, DEST_PORT_NUM=16'h0FA0, all tvalid passthrough.
2. reconfig_req at cycle 10 with no traffic → STOP@11, DRAIN@12, decouple=1 and rp_resetn=0 from cycle 13. reconfig_done@20 → RESUME_CYCLES=16 later: ack pulse, decouple=0.
3. 3-beat packet, req asserted after beat 1 accepted → beats 2 and 3 accepted. The next packet's first beat sees s_axis_tready=0 until ack.
4. Packet entered RP, downstream m_axis_tready=0 for 50 cycles → state stays DRAIN with count=1. Egress tlast accepted → DECOUPLE next cycle, timeout_err=0.
5. DRAIN_TIMEOUT=16, RP never emits tlast → decouple=1 exactly 16 cycles after DRAIN entry, timeout_err=1 sticky after return to RUN.
6. cfg_wr=16'd5000 while in DECOUPLE → DEST_PORT_NUM stays 4000 until the ack cycle, then 5000. cfg_wr in RUN updates next cycle.
